// File: rtl/sound_arbiter.sv
// sound_arbiter: grants one of three note requesters (live hit > record
// playback > song autoplay) access to a single sound engine, sequencing
// START -> PLAY -> GAP with preemption, watchdog timeout and enable abort.
// Ports: clk/rst (sync, active-high), en, req[2:0] with packed per-requester
// note fields, snd_over from the engine; registered ack/done/aborted pulses,
// snd_start/snd_abort pulses, latched snd_* note, busy and sticky timeout.
module sound_arbiter #(
  parameter int OCT_W      = 3,
  parameter int NOTE_W     = 3,
  parameter int LEN_W      = 3,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1 << 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          req,
  input  logic [3*OCT_W-1:0]  req_oct,
  input  logic [3*NOTE_W-1:0] req_note,
  input  logic [3*LEN_W-1:0]  req_len,
  input  logic                snd_over,
  output logic [2:0]          ack,
  output logic [2:0]          done,
  output logic [2:0]          aborted,
  output logic                snd_start,
  output logic                snd_abort,
  output logic [OCT_W-1:0]    snd_oct,
  output logic [NOTE_W-1:0]   snd_note,
  output logic [LEN_W-1:0]    snd_len,
  output logic                busy,
  output logic                timeout
);

  typedef enum logic [1:0] {IDLE, START, PLAY, GAP} state_t;

  // Play counter must be able to hold TIMEOUT itself without wrapping.
  localparam int CNT_W    = $clog2(TIMEOUT + 1);
  localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  // With no gap configured the FSM skips GAP and lands straight in IDLE.
  localparam state_t AFTER_PLAY = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [CNT_W-1:0]    play_cnt_q, play_cnt_d, play_inc;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [2:0]          ack_q, ack_d, done_q, done_d, aborted_q, aborted_d;
  logic                start_q, start_d, sabort_q, sabort_d;
  logic [OCT_W-1:0]    oct_q, oct_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                busy_q, busy_d, timeout_q, timeout_d;
  logic [2:0]          owner_oh;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    play_cnt_d = play_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ack_d      = '0;
    done_d     = '0;
    aborted_d  = '0;
    start_d    = 1'b0;
    sabort_d   = 1'b0;
    oct_d      = oct_q;
    note_d     = note_q;
    len_d      = len_q;
    timeout_d  = timeout_q;
    owner_oh   = 3'b001 << owner_q;
    play_inc   = play_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        gap_cnt_d = '0;
        if (en && (req != 3'b000)) begin
          // Walk downwards so the lowest asserted index is the one kept.
          for (int i = 2; i >= 0; i--) begin
            if (req[i]) begin
              owner_d  = 2'(i);
              ack_d    = '0;
              ack_d[i] = 1'b1;
              oct_d    = req_oct[i*OCT_W +: OCT_W];
              note_d   = req_note[i*NOTE_W +: NOTE_W];
              len_d    = req_len[i*LEN_W +: LEN_W];
            end
          end
          state_d = START;
        end
      end
      START: begin
        if (!en) begin
          sabort_d  = 1'b1;
          aborted_d = owner_oh;
          state_d   = IDLE;
        end else begin
          start_d    = 1'b1;
          play_cnt_d = '0;
          state_d    = PLAY;
        end
      end
      PLAY: begin
        gap_cnt_d = '0;
        if (!en) begin
          sabort_d  = 1'b1;
          aborted_d = owner_oh;
          state_d   = IDLE;
        end else if ((play_cnt_q != '0) && snd_over) begin
          // First PLAY cycle skipped: snd_over may still be high from the
          // previous note. Completion outranks a simultaneous preemption.
          done_d  = owner_oh;
          state_d = AFTER_PLAY;
        end else if ((owner_q != 2'd0) && req[0]) begin
          sabort_d  = 1'b1;
          aborted_d = owner_oh;
          state_d   = AFTER_PLAY;
        end else if (play_inc == CNT_W'(TIMEOUT)) begin
          sabort_d  = 1'b1;
          aborted_d = owner_oh;
          timeout_d = 1'b1;
          state_d   = AFTER_PLAY;
        end else begin
          play_cnt_d = play_inc;
        end
      end
      GAP: begin
        if (!en || (gap_cnt_q >= GAP_W'(GAP_LAST))) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else if (gap_cnt_q != GAP_W'(GAP_CYCLES)) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      play_cnt_q <= '0;
      gap_cnt_q  <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      aborted_q  <= '0;
      start_q    <= 1'b0;
      sabort_q   <= 1'b0;
      oct_q      <= '0;
      note_q     <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      play_cnt_q <= play_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      start_q    <= start_d;
      sabort_q   <= sabort_d;
      oct_q      <= oct_d;
      note_q     <= note_d;
      len_q      <= len_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign snd_start = start_q;
  assign snd_abort = sabort_q;
  assign snd_oct   = oct_q;
  assign snd_note  = note_q;
  assign snd_len   = len_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter with GAP_CYCLES=2 and TIMEOUT=16.
// Inputs are driven 1ns after each rising edge; outputs are checked there too.
module tb_sound_arbiter;

  logic       clk = 1'b0;
  logic       rst, en, snd_over;
  logic [2:0] req;
  logic [8:0] req_oct, req_note, req_len;
  logic [2:0] ack, done, aborted;
  logic       snd_start, snd_abort, busy, timeout;
  logic [2:0] snd_oct, snd_note, snd_len;

  int n_cmp = 0;
  int n_bad = 0;

  sound_arbiter #(
    .OCT_W(3), .NOTE_W(3), .LEN_W(3), .GAP_CYCLES(2), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .req_oct(req_oct), .req_note(req_note), .req_len(req_len),
    .snd_over(snd_over), .ack(ack), .done(done), .aborted(aborted),
    .snd_start(snd_start), .snd_abort(snd_abort),
    .snd_oct(snd_oct), .snd_note(snd_note), .snd_len(snd_len),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields();
    // requester 0: 1/2/3, requester 1: 4/5/2, requester 2: 6/7/1
    req_oct  = {3'd6, 3'd4, 3'd1};
    req_note = {3'd7, 3'd5, 3'd2};
    req_len  = {3'd1, 3'd2, 3'd3};
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; req = 3'b000; snd_over = 1'b0;
    set_fields();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 3'b111; snd_over = 1'b1;
    set_fields();
    tick();
    n_cmp++;
    if ({ack, done, aborted, snd_start, snd_abort, busy, timeout} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 0", {ack, done, aborted, snd_start, snd_abort, busy, timeout});
    end
    n_cmp++;
    if ({snd_oct, snd_note, snd_len} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_snd: got %h want 0", {snd_oct, snd_note, snd_len});
    end
    tick();
    n_cmp++;
    if ({ack, busy} !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_prio: got %b want 0", {ack, busy});
    end
  endtask

  task automatic test_priority();
    do_reset();
    req = 3'b110;
    tick();
    n_cmp++;
    if (ack !== 3'b010) begin n_bad++; $display("FAIL prio_ack: got %b want 010", ack); end
    n_cmp++;
    if ({snd_oct, snd_note, snd_len} !== {3'd4, 3'd5, 3'd2}) begin
      n_bad++;
      $display("FAIL prio_fields: got %0d/%0d/%0d want 4/5/2", snd_oct, snd_note, snd_len);
    end
    n_cmp++;
    if ({snd_start, busy} !== 2'b01) begin n_bad++; $display("FAIL prio_start_early: got %b want 01", {snd_start, busy}); end
    req = 3'b000;
    req_oct = 9'h1FF; req_note = 9'h000; req_len = 9'h1FF;
    tick();
    n_cmp++;
    if ({snd_start, ack} !== 4'b1000) begin n_bad++; $display("FAIL prio_start: got %b want 1000", {snd_start, ack}); end
    n_cmp++;
    if ({snd_oct, snd_note, snd_len} !== {3'd4, 3'd5, 3'd2}) begin
      n_bad++;
      $display("FAIL prio_hold: got %0d/%0d/%0d want 4/5/2", snd_oct, snd_note, snd_len);
    end
    set_fields();
  endtask

  task automatic test_done();
    do_reset();
    req = 3'b100;
    tick();
    n_cmp++;
    if (ack !== 3'b100) begin n_bad++; $display("FAIL done_ack: got %b want 100", ack); end
    req = 3'b000;
    tick();                       // PLAY cycle 1
    snd_over = 1'b1;              // stale level, must be ignored
    tick();                       // PLAY cycle 2
    snd_over = 1'b0;
    n_cmp++;
    if ({done, busy} !== 4'b0001) begin n_bad++; $display("FAIL done_stale: got %b want 0001", {done, busy}); end
    for (int i = 0; i < 8; i++) tick();   // PLAY cycle 10
    snd_over = 1'b1;
    tick();
    snd_over = 1'b0;
    n_cmp++;
    if ({done, aborted, snd_abort} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL done_pulse: got %b want 1000000", {done, aborted, snd_abort});
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 4'b0001) begin n_bad++; $display("FAIL done_gap1: got %b want 0001", {done, busy}); end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL done_idle: got %b want 0", busy); end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 3'b010;
    tick();                       // ack
    req = 3'b000;
    tick();                       // PLAY 1
    tick();                       // PLAY 2
    req = 3'b001;
    tick();
    n_cmp++;
    if ({snd_abort, aborted, done, ack} !== 10'b1_010_000_000) begin
      n_bad++;
      $display("FAIL preempt_abort: got %b want 1010000000", {snd_abort, aborted, done, ack});
    end
    tick();                       // GAP 2
    n_cmp++;
    if (ack !== 3'b000) begin n_bad++; $display("FAIL preempt_gap_ack: got %b want 000", ack); end
    tick();                       // IDLE
    n_cmp++;
    if ({ack, busy} !== 4'b0000) begin n_bad++; $display("FAIL preempt_idle: got %b want 0000", {ack, busy}); end
    tick();
    n_cmp++;
    if (ack !== 3'b001) begin n_bad++; $display("FAIL preempt_ack0: got %b want 001", ack); end
    tick();                       // PLAY 1 of live hit, req[0] still high
    tick();
    n_cmp++;
    if ({snd_abort, aborted} !== 4'b0000) begin
      n_bad++;
      $display("FAIL live_no_preempt: got %b want 0000", {snd_abort, aborted});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 3'b100;
    tick();
    req = 3'b000;
    tick();
    tick();
    snd_over = 1'b1; req = 3'b001;
    tick();
    snd_over = 1'b0; req = 3'b000;
    n_cmp++;
    if ({done, aborted, snd_abort} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL simul: got %b want 1000000", {done, aborted, snd_abort});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 3'b010;
    tick();
    req = 3'b000;
    tick();                       // PLAY 1
    for (int i = 0; i < 15; i++) tick();   // PLAY 16
    n_cmp++;
    if ({aborted, timeout} !== 4'b0000) begin
      n_bad++;
      $display("FAIL to_early: got %b want 0000", {aborted, timeout});
    end
    tick();
    n_cmp++;
    if ({aborted, snd_abort, timeout} !== 5'b01011) begin
      n_bad++;
      $display("FAIL to_fire: got %b want 01011", {aborted, snd_abort, timeout});
    end
    tick(); tick(); tick();
    n_cmp++;
    if ({timeout, busy, aborted} !== 5'b10000) begin
      n_bad++;
      $display("FAIL to_sticky: got %b want 10000", {timeout, busy, aborted});
    end
    do_reset();
    n_cmp++;
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b want 0", timeout); end
  endtask

  task automatic test_en_drop();
    do_reset();
    req = 3'b001;
    tick();
    tick();
    tick();
    en = 1'b0; req = 3'b111;
    tick();
    n_cmp++;
    if ({snd_abort, aborted, busy, done} !== 8'b1_001_0_000) begin
      n_bad++;
      $display("FAIL en_abort: got %b want 10010000", {snd_abort, aborted, busy, done});
    end
    tick();
    n_cmp++;
    if ({snd_abort, ack} !== 4'b0000) begin n_bad++; $display("FAIL en_noack1: got %b want 0000", {snd_abort, ack}); end
    tick();
    n_cmp++;
    if ({ack, busy} !== 4'b0000) begin n_bad++; $display("FAIL en_noack2: got %b want 0000", {ack, busy}); end
    en = 1'b1;
    tick();
    n_cmp++;
    if (ack !== 3'b001) begin n_bad++; $display("FAIL en_resume: got %b want 001", ack); end
  endtask

  task automatic test_rst_mid_play();
    do_reset();
    req = 3'b100;
    tick();
    req = 3'b000;
    tick();
    tick();
    rst = 1'b1; snd_over = 1'b1; req = 3'b001;
    tick();
    n_cmp++;
    if ({snd_abort, done, aborted, busy} !== 8'd0) begin
      n_bad++;
      $display("FAIL rst_play: got %b want 00000000", {snd_abort, done, aborted, busy});
    end
    rst = 1'b0; snd_over = 1'b0; req = 3'b000;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_done();
    test_preempt();
    test_simultaneous();
    test_timeout();
    test_en_drop();
    test_rst_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter OCT_W, 3, octave field width.
REQ-002 Parameter NOTE_W, 3, note field width.
REQ-003 Parameter LEN_W, 3, length field width.
REQ-004 Parameter GAP_CYCLES, 2, silent cycles between consecutive notes (0 allowed).
REQ-005 Parameter TIMEOUT, 2^24, maximum PLAY cycles before a note is force-ended.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 en  input  1  block enable; low aborts activity and blocks arbitration.
REQ-009 req  input  3  requests: bit0 live hit, bit1 record playback, bit2 song autoplay.
REQ-010 req_oct/req_note/req_len  input  3*OCT_W/3*NOTE_W/3*LEN_W  per-requester note fields, requester i in slice i.
REQ-011 snd_over  input  1  sound engine reports note finished, level.
REQ-012 ack  output  3  one-cycle pulse, fields of requester i latched.
REQ-013 done  output  3  one-cycle pulse, requester i's note completed normally.
REQ-014 aborted  output  3  one-cycle pulse, requester i's note cut short.
REQ-015 snd_start  output  1  one-cycle pulse starting engine.
REQ-016 snd_abort  output  1  one-cycle pulse silencing engine.
REQ-017 snd_oct/snd_note/snd_len  output  OCT_W/NOTE_W/LEN_W  latched note to engine, held stable until next latch.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 timeout  output  1  sticky flag, set on watchdog expiry.

Function
REQ-020 States SHALL be IDLE, START, PLAY, GAP, encoded in a registered FSM; all outputs registered.
REQ-021 IDLE with en=1 and req!=0: select lowest-index asserted bit (fixed priority 0>1>2), latch its fields into snd_*, pulse ack[i] next cycle, record owner, go START.
REQ-022 START: pulse snd_start for exactly one cycle, clear PLAY counter, go PLAY.
REQ-023 PLAY: snd_over SHALL be ignored in the first PLAY cycle (stale level from prior note).
REQ-024 PLAY, counter>=1 and snd_over=1: pulse done[owner], go GAP.
REQ-025 PLAY with owner!=0 and req[0]=1 (preemption): pulse snd_abort and aborted[owner], go GAP; live-hit owner is never preempted.
REQ-026 snd_over and preemption in same cycle: normal completion wins (done, no abort).
REQ-027 PLAY counter reaching TIMEOUT: pulse snd_abort and aborted[owner], set timeout, go GAP.
REQ-028 GAP: stay exactly GAP_CYCLES cycles, then IDLE; GAP_CYCLES=0 returns to IDLE the cycle after leaving PLAY.
REQ-029 Arbitration only in IDLE; requests arriving elsewhere wait, no ack.
REQ-030 Requester may drop req after ack; later changes to req_* SHALL not alter snd_*.
REQ-031 en=0 in START or PLAY: pulse snd_abort and aborted[owner] next cycle, go IDLE (no GAP); en=0 in GAP: go IDLE; no ack while en=0.
REQ-032 ack, done, aborted SHALL each be one-hot or zero; at most one of them non-zero per cycle.
REQ-033 PLAY counter width SHALL hold TIMEOUT without wrap; GAP counter SHALL saturate at GAP_CYCLES.

Reset
REQ-034 rst=1 at a clock edge: state IDLE, owner 0, all pulses 0, snd_oct/snd_note/snd_len 0, busy 0, timeout 0, counters 0.
REQ-035 rst mid-PLAY SHALL not emit snd_abort, done or aborted; engine silencing is the engine's own reset.
REQ-036 rst has priority over en and all inputs.

Verification
REQ-037 req=3'b110 from IDLE, fields of req1 = oct 4, note 5, len 2 -> ack=3'b010 next cycle, snd_start the following cycle, snd_*=4/5/2.
REQ-038 Owner 2 in PLAY, snd_over high at PLAY cycle 10 -> done=3'b100 one cycle, busy low exactly 2 cycles later (GAP_CYCLES=2).
REQ-039 Owner 1 in PLAY, req[0] pulses -> snd_abort and aborted=3'b010 same cycle, after GAP ack=3'b001.
REQ-040 snd_over and req[0] asserted same PLAY cycle, owner 2 -> done=3'b100, aborted=0, snd_abort=0.
REQ-041 TIMEOUT=16, snd_over never asserted -> aborted[owner] and timeout=1 after 16 PLAY cycles; timeout stays 1 until rst.
REQ-042 en dropped in PLAY -> snd_abort next cycle, state IDLE, no ack while en=0 despite req=3'b111.
